// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: base encodings,
// biased-zero helper and the target feeder state enum.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_G = 2'b01;
  localparam logic [1:0] BASE_T = 2'b10;
  localparam logic [1:0] BASE_C = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } feed_state_t;

  function automatic int unsigned sw_zero(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_base_fifo.sv
// Synchronous FIFO for {last, base} entries; async active-high reset.
// Ports: wr_en/wr_data in, rd_en in, rd_data (head, comb), full, empty, count.
module sw_base_fifo
  import sw_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sw_target_feeder.sv
// Front end of the SW systolic array: buffers target bases, frames
// sequences, alternates toggle slots, gates launch on done0/done1.
// Ports: s_valid/s_ready/s_base/s_last source, done0/done1 from tail,
// data_out/en_out/toggle_out + M_out/I_out/High_out to PE0, underrun.
// Optional SW_FEEDER_STATS_EN adds seq_cnt and base_cnt outputs.
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int          SCORE_WIDTH = 12,
  parameter int unsigned ZERO        = sw_zero(SCORE_WIDTH),
  parameter int          FIFO_DEPTH  = 16,
  parameter int          GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  input  logic                   done0,
  input  logic                   done1,
  output logic [1:0]             data_out,
  output logic                   en_out,
  output logic                   toggle_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic                   underrun
`ifdef SW_FEEDER_STATS_EN
  ,
  output logic [15:0]            seq_cnt,
  output logic [23:0]            base_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SCORE_WIDTH-1:0] ZERO_W = SCORE_WIDTH'(ZERO);

  feed_state_t   state;
  logic [2:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fcount;
  logic [CW-1:0] cseq;
  logic          push;
  logic          pop;
  logic          launch;
  logic          nxt_tog;
  logic [1:0]    inflight;
  logic          done0_q;
  logic          done1_q;
  logic          rise0;
  logic          rise1;
  logic [GW-1:0] gcnt;

  assign M_out    = ZERO_W;
  assign I_out    = ZERO_W;
  assign High_out = ZERO_W;

  assign s_ready = (fcount != CW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state == STREAM) && !empty;
  assign rise0   = done0 && !done0_q;
  assign rise1   = done1 && !done1_q;

  // A full buffer with no last entry still launches, so one
  // over-long sequence cannot deadlock the source.
  assign launch = (state == IDLE) && !empty &&
                  ((cseq != '0) || full) && !inflight[nxt_tog];

  sw_base_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({s_last, s_base}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fcount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cseq <= '0;
    end else begin
      unique case ({push && s_last, pop && head[2]})
        2'b10:   cseq <= cseq + 1'b1;
        2'b01:   cseq <= cseq - 1'b1;
        default: ;
      endcase
    end
  end

  // Launch sets its own slot only when that slot is clear, so a
  // set taking priority over a same-cycle rise never loses a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      inflight <= 2'b00;
    end else begin
      done0_q <= done0;
      done1_q <= done1;
      if (launch && !nxt_tog) inflight[0] <= 1'b1;
      else if (rise0)         inflight[0] <= 1'b0;
      if (launch && nxt_tog)  inflight[1] <= 1'b1;
      else if (rise1)         inflight[1] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      en_out     <= 1'b0;
      data_out   <= 2'b00;
      toggle_out <= 1'b0;
      nxt_tog    <= 1'b0;
      underrun   <= 1'b0;
      gcnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          en_out   <= 1'b0;
          data_out <= 2'b00;
          if (launch) begin
            toggle_out <= nxt_tog;
            state      <= STREAM;
          end
        end
        STREAM: begin
          gcnt <= '0;
          if (!empty) begin
            en_out   <= 1'b1;
            data_out <= head[1:0];
            if (head[2]) state <= GAP;
          end else begin
            en_out   <= 1'b0;
            data_out <= 2'b00;
            underrun <= 1'b1;
            state    <= GAP;
          end
        end
        GAP: begin
          en_out   <= 1'b0;
          data_out <= 2'b00;
          if (gcnt == GW'(GAP_CYCLES - 1)) begin
            nxt_tog <= ~nxt_tog;
            state   <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SW_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt  <= '0;
      base_cnt <= '0;
    end else begin
      if (launch) seq_cnt  <= seq_cnt + 16'd1;
      if (pop)    base_cnt <= base_cnt + 24'd1;
    end
  end
`endif

endmodule
